// File: rtl/hack_alu_pkg.sv
// Shared types and Hack ALU function codes for sequencers built around alu_optimized2.
// Pure declarations; no logic.
package hack_alu_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} mul_state_t;

    // fn = {zx, nx, zy, ny, f, no}
    localparam logic [5:0] FN_ZERO      = 6'b101010;
    localparam logic [5:0] FN_ONE       = 6'b111111;
    localparam logic [5:0] FN_NEG_ONE   = 6'b111010;
    localparam logic [5:0] FN_X         = 6'b001100;
    localparam logic [5:0] FN_Y         = 6'b110000;
    localparam logic [5:0] FN_NOT_X     = 6'b001101;
    localparam logic [5:0] FN_NOT_Y     = 6'b110001;
    localparam logic [5:0] FN_NEG_X     = 6'b001111;
    localparam logic [5:0] FN_NEG_Y     = 6'b110011;
    localparam logic [5:0] FN_X_PLUS_1  = 6'b011111;
    localparam logic [5:0] FN_Y_PLUS_1  = 6'b110111;
    localparam logic [5:0] FN_X_MINUS_1 = 6'b001110;
    localparam logic [5:0] FN_Y_MINUS_1 = 6'b110010;
    localparam logic [5:0] FN_X_PLUS_Y  = 6'b000010;
    localparam logic [5:0] FN_X_MINUS_Y = 6'b010011;
    localparam logic [5:0] FN_Y_MINUS_X = 6'b000111;
    localparam logic [5:0] FN_X_AND_Y   = 6'b000000;
    localparam logic [5:0] FN_X_OR_Y    = 6'b010101;

endpackage

// File: rtl/hack_mul_seq_if.sv
// Request/response handshake bundle for the sequential multiplier.
// slave = multiplier side, master = requester side.
interface hack_mul_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_prod;
    logic        resp_zero;
    logic        resp_neg;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_prod, resp_zero, resp_neg
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_prod, resp_zero, resp_neg
    );
endinterface

// File: rtl/alu_optimized2.sv
// Hack ALU: 16-bit combinational datapath controlled by {zx,nx,zy,ny,f,no}.
// Latency: combinational. Backpressure: none.
module alu_optimized2 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [5:0]  fn,
    output logic [15:0] out,
    output logic        zero,
    output logic        neg
);
    logic [15:0] xz, xn, yz, yn, r;

    always_comb begin
        xz   = fn[5] ? 16'h0000 : x;
        xn   = fn[4] ? ~xz : xz;
        yz   = fn[3] ? 16'h0000 : y;
        yn   = fn[2] ? ~yz : yz;
        r    = fn[1] ? (xn + yn) : (xn & yn);
        out  = fn[0] ? ~r : r;
        zero = (out == 16'h0000);
        neg  = out[15];
    end
endmodule

// File: rtl/hack_mul_seq.sv
// Shift-and-add 16x16 multiplier (low 16 bits) sequencing one Hack ALU in x+y mode.
// Latency: 16 + popcount(b) cycles; with HACK_MUL_EARLY_EXIT_EN stops after the multiplier's top set bit.
// Backpressure: one request in flight; result held in DONE until resp_ready.
module hack_mul_seq
    import hack_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    hack_mul_seq_if.slave   mul
);
    mul_state_t  state_q, state_d;
    logic [15:0] prod_q, prod_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zero_unused, alu_neg_unused;
    logic        last_step;

    alu_optimized2 u_alu (
        .x    (alu_x),
        .y    (alu_y),
        .fn   (FN_X_PLUS_Y),
        .out  (alu_out),
        .zero (alu_zero_unused),
        .neg  (alu_neg_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        prod_d         = prod_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        cnt_d          = cnt_q;
        alu_x          = '0;
        alu_y          = '0;
        last_step      = 1'b0;
        mul.req_ready  = 1'b0;
        mul.resp_valid = 1'b0;
        mul.resp_prod  = prod_q;
        mul.resp_zero  = (prod_q == 16'h0000);
        mul.resp_neg   = prod_q[15];

        case (state_q)
            IDLE: begin
                mul.req_ready = 1'b1;
                if (mul.req_valid) begin
                    prod_d   = '0;
                    mcand_d  = mul.req_a;
                    mplier_d = mul.req_b;
                    cnt_d    = '0;
                    state_d  = mul.req_b[0] ? ADD : DBL;
`ifdef HACK_MUL_EARLY_EXIT_EN
                    if (mul.req_b == 16'h0000) state_d = DONE;
`endif
                end
            end
            ADD: begin
                alu_x   = prod_q;
                alu_y   = mcand_q;
                prod_d  = alu_out;
                state_d = DBL;
            end
            DBL: begin
                alu_x    = mcand_q;
                alu_y    = mcand_q;
                mcand_d  = alu_out;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                last_step = (cnt_q == 4'd15);
`ifdef HACK_MUL_EARLY_EXIT_EN
                // No set bits left above the one just consumed: the product is final.
                if (mplier_q[15:1] == 15'h0000) last_step = 1'b1;
`endif
                if (last_step)        state_d = DONE;
                else if (mplier_q[1]) state_d = ADD;
                else                  state_d = DBL;
            end
            DONE: begin
                mul.resp_valid = 1'b1;
                if (mul.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hack_mul_seq.sv
// Randomized and directed checks of hack_mul_seq against a product/latency reference model.
module tb_hack_mul_seq;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    hack_mul_seq_if mif ();

    hack_mul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mul   (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_lat(input logic [15:0] b);
        int pop;
        int msb;
        pop = 0;
        msb = -1;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                pop++;
                msb = i;
            end
        end
`ifdef HACK_MUL_EARLY_EXIT_EN
        return (msb + 1) + pop;
`else
        return 16 + pop;
`endif
    endfunction

    function automatic logic [15:0] model_prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] full;
        full = {16'h0000, a} * {16'h0000, b};
        return full[15:0];
    endfunction

    // Issue one request, wait for its response, then complete the handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] p, output logic z, output logic n,
                          output int lat, output bit to);
        int w;
        to = 1'b0;
        w  = 0;
        mif.req_a     = a;
        mif.req_b     = b;
        mif.req_valid = 1'b1;
        while (mif.req_ready !== 1'b1 && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 200) to = 1'b1;
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        mif.req_a     = 16'($urandom);
        mif.req_b     = 16'($urandom);
        lat = 0;
        while (mif.resp_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 200) to = 1'b1;
        p = mif.resp_prod;
        z = mif.resp_zero;
        n = mif.resp_neg;
        mif.resp_ready = 1'b1;
        @(posedge clk); #1;
        mif.resp_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p, ep;
        logic z, n;
        int lat, elat;
        bit to;
        run_op(a, b, p, z, n, lat, to);
        ep   = model_prod(a, b);
        elat = model_lat(b);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL %s timeout a=%h b=%h got no response, required one", name, a, b);
        end
        tests++;
        if ({p, z, n} !== {ep, ep == 16'h0000, ep[15]}) begin
            fails++;
            $display("FAIL %s result a=%h b=%h got prod=%h z=%b n=%b, required prod=%h z=%b n=%b",
                     name, a, b, p, z, n, ep, ep == 16'h0000, ep[15]);
        end
        tests++;
        if (lat != elat) begin
            fails++;
            $display("FAIL %s latency a=%h b=%h got %0d, required %0d", name, a, b, lat, elat);
        end
    endtask

    task automatic test_reset();
        mif.req_valid  = 1'b0;
        mif.req_a      = '0;
        mif.req_b      = '0;
        mif.resp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({mif.req_ready, mif.resp_valid, mif.resp_prod, mif.resp_zero, mif.resp_neg}
            !== {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_outputs got rdy=%b vld=%b prod=%h z=%b n=%b, required 1 0 0000 1 0",
                     mif.req_ready, mif.resp_valid, mif.resp_prod, mif.resp_zero, mif.resp_neg);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (mif.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset got %b, required 1", mif.req_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [6];
        logic [15:0] tb [6];
        logic [15:0] tp [6];
        ta = '{16'd3, 16'hFFFF, 16'h0100, 16'h1234, 16'd5, 16'd1};
        tb = '{16'd5, 16'hFFFF, 16'h0100, 16'h0000, 16'h0004, 16'h8000};
        tp = '{16'd15, 16'h0001, 16'h0000, 16'h0000, 16'd20, 16'h8000};
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (model_prod(ta[i], tb[i]) !== tp[i]) begin
                fails++;
                $display("FAIL directed_model %0d got %h, required %h", i, model_prod(ta[i], tb[i]), tp[i]);
            end
            check_op($sformatf("directed%0d", i), ta[i], tb[i]);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 16'($urandom >> $urandom_range(0, 31));
            check_op("random", a, b);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b, a2, b2, p0;
        int lat;
        bit ok;
        a  = 16'($urandom);
        b  = 16'($urandom);
        a2 = 16'($urandom);
        b2 = 16'($urandom);
        mif.req_a = a; mif.req_b = b; mif.req_valid = 1'b1;
        @(posedge clk); #1;
        mif.req_a = a2; mif.req_b = b2;
        lat = 0;
        while (mif.resp_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        p0 = mif.resp_prod;
        tests++;
        if (lat >= 200 || p0 !== model_prod(a, b)) begin
            fails++;
            $display("FAIL bp_first got prod=%h after %0d cycles, required %h", p0, lat, model_prod(a, b));
        end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (mif.resp_valid !== 1'b1 || mif.resp_prod !== p0 || mif.req_ready !== 1'b0) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_hold got vld=%b prod=%h rdy=%b, required 1 %h 0",
                     mif.resp_valid, mif.resp_prod, mif.req_ready, p0);
        end
        mif.resp_ready = 1'b1;
        @(posedge clk); #1;
        mif.resp_ready = 1'b0;
        tests++;
        if (mif.req_ready !== 1'b1 || mif.resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release got rdy=%b vld=%b, required 1 0", mif.req_ready, mif.resp_valid);
        end
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        tests++;
        if (mif.req_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept got rdy=%b, required 0", mif.req_ready);
        end
        lat = 0;
        while (mif.resp_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        tests++;
        if (mif.resp_prod !== model_prod(a2, b2) || lat != model_lat(b2)) begin
            fails++;
            $display("FAIL bp_second got prod=%h lat=%0d, required prod=%h lat=%0d",
                     mif.resp_prod, lat, model_prod(a2, b2), model_lat(b2));
        end
        mif.resp_ready = 1'b1;
        @(posedge clk); #1;
        mif.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        mif.req_a = 16'd7; mif.req_b = 16'd9; mif.req_valid = 1'b1;
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({mif.req_ready, mif.resp_valid, mif.resp_prod, mif.resp_zero, mif.resp_neg}
            !== {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL midreset_outputs got rdy=%b vld=%b prod=%h z=%b n=%b, required 1 0 0000 1 0",
                     mif.req_ready, mif.resp_valid, mif.resp_prod, mif.resp_zero, mif.resp_neg);
        end
        #2;
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (mif.resp_valid !== 1'b0) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL midreset_no_resp got resp_valid=1, required 0");
        end
        check_op("after_reset", 16'd2, 16'd3);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hack_mul_seq.md
# hack_mul_seq

Multi-cycle 16-bit multiplier built by sequencing a single instance of the team's Hack ALU (`alu_optimized2`) through shift-and-add steps.
- The ALU is used only with its x+y function code; the sequencer owns all operand muxing and state.
- Requests arrive on a valid/ready port; products leave on a valid/ready port with zero and negative flags.
- It sits beside the CPU datapath as a coprocessor for the Hack `MUL` extension; the result is the low 16 bits of the product (modulo 2^16, two's-complement consistent).

## Interface
- No parameters; width fixed at 16.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_a`  in  16  multiplicand
- `req_b`  in  16  multiplier
- `resp_valid`  out  1  product available
- `resp_ready`  in  1  consumer takes product
- `resp_prod`  out  16  low 16 bits of a*b
- `resp_zero`  out  1  `resp_prod == 0`
- `resp_neg`  out  1  `resp_prod[15]`

## Operation
- Registers:
  - `prod` (16): accumulated product.
  - `mcand` (16): multiplicand, doubled each step.
  - `mplier` (16): multiplier, shifted right each step.
  - `cnt` (4): bit index.
  - `state`: IDLE, ADD, DBL, DONE.
- ALU is driven with fn=`6'b000010` (x+y) at all times; the state selects operands:
  - ADD: x=`prod`, y=`mcand`.
  - DBL: x=`mcand`, y=`mcand`.
  - IDLE/DONE: operands don't-care.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, load:
  - `prod`=0, `mcand`=`req_a`, `mplier`=`req_b`, `cnt`=0.
  - Next state is ADD if `req_b[0]`, else DBL.
- ADD: `prod` <= ALU out; go to DBL.
- DBL:
  - `mcand` <= ALU out; `mplier` <= `mplier>>1`; `cnt` <= `cnt+1`.
  - If `cnt==15`, go to DONE.
  - Otherwise go to ADD if `mplier[1]`, else DBL.
- DONE: `resp_valid`=1. On `resp_ready`, go to IDLE.
- `resp_prod`/`resp_zero`/`resp_neg` are driven combinationally from `prod`. They are stable throughout DONE and meaningful only when `resp_valid`=1.
- Additions wrap modulo 2^16; no carry or overflow is tracked.
- No request is accepted in ADD, DBL or DONE. Back-to-back throughput is therefore one request per (latency + 2) cycles.

## Timing
- Reset (async assert, sync-safe deassert) sets:
  - state=IDLE; `prod`, `mcand`, `mplier`, `cnt` = 0.
  - `req_ready`=1, `resp_valid`=0, `resp_prod`=0, `resp_zero`=1, `resp_neg`=0.
- Latency: take the accept edge as edge 0. `resp_valid` goes high after edge N, where N = 16 + popcount(`req_b`) without the feature.
- `resp_valid` holds with stable data while `resp_ready`=0, indefinitely.
- With `resp_valid & resp_ready` on edge k:
  - After edge k, the block is in IDLE with `req_ready`=1.
  - The earliest next accept is edge k+1.
- Reset asserted mid-operation aborts immediately: all state is cleared and no response is produced.
- `req_a`/`req_b` are sampled only on the accept edge; later changes are ignored.

## Configuration
- `HACK_MUL_EARLY_EXIT_EN` defined:
  - In IDLE, accepting `req_b==0` goes directly to DONE (N=0: `resp_valid` high right after the accept edge).
  - In DBL, if `(mplier>>1)==0`, go to DONE regardless of `cnt`.
  - Resulting latency: N = (index of MSB set in `req_b` + 1) + popcount(`req_b`).
- Undefined: fixed 16 DBL steps, as in Operation.
- Products are identical in both builds; only latency differs.

## Structure
- Package `hack_alu_pkg`:
  - `typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} mul_state_t`.
  - Localparam `FN_X_PLUS_Y = 6'b000010`, plus the other Hack fn codes for reuse by future sequencers.
- One sub-module: a single `alu_optimized2` instance. Its `zero` output is unused.
- Everything else lives in one always_ff block (registers/state) and one always_comb block (next state, operand mux).

## Test plan
- Reset, then a=3, b=5 -> `req_ready`=1 before the request; `resp_valid` after edge 18; `resp_prod`=15, zero=0, neg=0.
- a=16'hFFFF, b=16'hFFFF -> `resp_prod`=16'h0001 after edge 32; a=16'h0100, b=16'h0100 -> `resp_prod`=0, zero=1.
- a=16'h1234, b=0 -> `resp_prod`=0, zero=1; N=16 without the macro, N=0 with it.
- `resp_ready` held low 10 cycles in DONE -> `resp_valid` and `resp_prod` stable; `req_valid` held high is not accepted until one cycle after the response handshake.
- `rst_n` pulsed low during ADD of a=7, b=9 -> outputs return to reset values asynchronously; the next request a=2, b=3 yields 6.
- With `HACK_MUL_EARLY_EXIT_EN`: a=5, b=16'h0004 -> `resp_prod`=20 after edge 4; a=1, b=16'h8000 -> `resp_prod`=16'h8000, neg=1, after edge 17.
